// File: rtl/safecrack_keypad_frontend.sv
`default_nettype none
// ============================================================================
// Module      : safecrack_keypad_frontend
// Description : Keypad front end for the safecrack controller. Synchronizes
//               and debounces four active-low buttons and a programming
//               switch, turns button presses into digit events, and holds one
//               digit in a valid/ready register for the consumer.
//               Optional macro KEYPAD_MULTI_PRESS_REJECT_EN: when defined,
//               simultaneous or overlapping presses are rejected with an
//               overflow pulse instead of resolving to the lowest index.
// Revision    : 1.0 - initial release
// ============================================================================
module safecrack_keypad_frontend #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_n,
  input  logic       prog_sw,
  output logic       digit_valid,
  output logic [1:0] digit,
  input  logic       digit_ready,
  output logic       prog_level,
  output logic       prog_rise,
  output logic       prog_fall,
  output logic       overflow
);

  localparam int             c_cnt_w   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);
  // Bit 4 is prog_sw (idle low); bits 3:0 are buttons (released high).
  localparam logic [4:0]     c_rst_val = 5'b01111;

  logic [4:0] w_raw;
  logic [4:0] r_sync1;
  logic [4:0] r_sync2;
  logic [4:0] w_stable;
  logic [4:0] r_stable_d;
  logic [3:0] w_press;
  logic [3:0] r_press;
  logic [1:0] w_sel;
  logic       w_reject;
  logic       r_valid;
  logic [1:0] r_digit;
  logic       r_overflow;
  logic       r_prog_rise;
  logic       r_prog_fall;

  assign w_raw = {prog_sw, btn_n};

  // Two-flop synchronizer on every raw input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= c_rst_val;
      r_sync2 <= c_rst_val;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  generate
    for (genvar g = 0; g < 5; g++) begin : g_debounce
      logic [c_cnt_w-1:0] r_cnt;
      logic               r_stable_bit;

      // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_cnt        <= '0;
          r_stable_bit <= c_rst_val[g];
        end else if (r_sync2[g] == r_stable_bit) begin
          r_cnt <= '0;
        end else if (r_cnt == c_cnt_max) begin
          r_stable_bit <= r_sync2[g];
          r_cnt        <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_stable[g] = r_stable_bit;
    end
  endgenerate

  // A press is a stable released->pressed transition; releases are ignored.
  assign w_press = r_stable_d[3:0] & ~w_stable[3:0];

  // Delayed stable state for edge detection, registered press events and prog pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stable_d  <= c_rst_val;
      r_press     <= 4'b0000;
      r_prog_rise <= 1'b0;
      r_prog_fall <= 1'b0;
    end else begin
      r_stable_d  <= w_stable;
      r_press     <= w_press;
      r_prog_rise <= w_stable[4] & ~r_stable_d[4];
      r_prog_fall <= ~w_stable[4] & r_stable_d[4];
    end
  end

  // Select the lowest-index press and decide whether the event must be rejected.
  always_comb begin
    w_sel = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (r_press[k]) begin
        w_sel = 2'(k);
      end
    end
`ifdef KEYPAD_MULTI_PRESS_REJECT_EN
    // Reject more than one simultaneous event, or an event while another button is down.
    w_reject = ((r_press & (r_press - 4'd1)) != 4'b0000) ||
               ((~w_stable[3:0] & ~r_press) != 4'b0000);
`else
    w_reject = 1'b0;
`endif
  end

  // Single-entry digit holding register with valid/ready handshake and overflow pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_digit    <= 2'd0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      if (r_valid && digit_ready) begin
        r_valid <= 1'b0;
      end
      if (r_press != 4'b0000) begin
        if (w_reject || (r_valid && !digit_ready)) begin
          r_overflow <= 1'b1;
        end else begin
          r_valid <= 1'b1;
          r_digit <= w_sel;
        end
      end
    end
  end

  assign digit_valid = r_valid;
  assign digit       = r_digit;
  assign overflow    = r_overflow;
  assign prog_level  = w_stable[4];
  assign prog_rise   = r_prog_rise;
  assign prog_fall   = r_prog_fall;

endmodule
`default_nettype wire

// File: tb/tb_safecrack_keypad_frontend.sv
`default_nettype none
// ============================================================================
// Module      : tb_safecrack_keypad_frontend
// Description : Self-checking bench for safecrack_keypad_frontend with
//               DEBOUNCE_CYCLES=4. Directed scenarios followed by random
//               stimulus, all compared every cycle against a queue-based
//               reference model of the keypad behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_safecrack_keypad_frontend;

  localparam int         D       = 4;
  localparam logic [4:0] RST_VAL = 5'b01111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_n;
  logic       prog_sw;
  logic       digit_valid;
  logic [1:0] digit;
  logic       digit_ready;
  logic       prog_level;
  logic       prog_rise;
  logic       prog_fall;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [4:0] m_sq[$];     // raw samples since reset (synchronizer delay)
  logic [4:0] m_win[$];    // last D synchronized samples since reset
  logic [3:0] m_pq[$];     // press-event masks per edge (event-to-load delay)
  logic [4:0] m_stable;
  logic       m_valid, m_ovf, m_rise, m_fall, m_level;
  logic [1:0] m_digit;
  logic       m_pr, m_pf;  // prog flips found on previous edge

  safecrack_keypad_frontend #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .prog_sw(prog_sw),
    .digit_valid(digit_valid), .digit(digit), .digit_ready(digit_ready),
    .prog_level(prog_level), .prog_rise(prog_rise), .prog_fall(prog_fall),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task model_edge();
    logic [4:0] raw, cmp, nstable;
    logic [3:0] ev, press;
    logic [1:0] sel;
    logic       rej, was_valid, differ;
    raw = {prog_sw, btn_n};
    if (!rst_n) begin
      m_sq.delete(); m_win.delete(); m_pq.delete();
      m_stable = RST_VAL;
      m_valid = 0; m_digit = 0; m_ovf = 0; m_rise = 0; m_fall = 0; m_level = 0;
      m_pr = 0; m_pf = 0;
    end else begin
      // Holding register: events surface two edges after the stable flip.
      ev = (m_pq.size() >= 2) ? m_pq[m_pq.size()-2] : 4'b0000;
      m_rise = m_pr;
      m_fall = m_pf;
      m_ovf = 0;
      was_valid = m_valid;
      if (was_valid && digit_ready) m_valid = 0;
      if (ev != 4'b0000) begin
        sel = 0;
        for (int i = 3; i >= 0; i--) if (ev[i]) sel = 2'(i);
`ifdef KEYPAD_MULTI_PRESS_REJECT_EN
        rej = ($countones(ev) > 1) || ((~m_stable[3:0] & ~ev) != 4'b0000);
`else
        rej = 0;
`endif
        if (rej || (was_valid && !digit_ready)) m_ovf = 1;
        else begin m_valid = 1; m_digit = sel; end
      end
      // Synchronized sample = raw from two edges ago, reset value before that.
      cmp = (m_sq.size() >= 2) ? m_sq[m_sq.size()-2] : RST_VAL;
      m_sq.push_back(raw);
      if (m_sq.size() > 2) void'(m_sq.pop_front());
      // Stable level flips when the last D samples all disagree with it.
      m_win.push_back(cmp);
      if (m_win.size() > D) void'(m_win.pop_front());
      nstable = m_stable;
      if (m_win.size() == D) begin
        for (int i = 0; i < 5; i++) begin
          differ = 1;
          for (int k = 0; k < D; k++) if (m_win[k][i] == m_stable[i]) differ = 0;
          if (differ) nstable[i] = ~m_stable[i];
        end
      end
      press = m_stable[3:0] & ~nstable[3:0];
      m_pr = ~m_stable[4] & nstable[4];
      m_pf = m_stable[4] & ~nstable[4];
      m_stable = nstable;
      m_level = nstable[4];
      m_pq.push_back(press);
      if (m_pq.size() > 2) void'(m_pq.pop_front());
    end
  endtask

  task tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("digit_valid", 8'(digit_valid), 8'(m_valid));
    chk("digit",       8'(digit),       8'(m_digit));
    chk("overflow",    8'(overflow),    8'(m_ovf));
    chk("prog_level",  8'(prog_level),  8'(m_level));
    chk("prog_rise",   8'(prog_rise),   8'(m_rise));
    chk("prog_fall",   8'(prog_fall),   8'(m_fall));
  endtask

  int first, ovf_cnt, rise_cnt, fall_cnt, r;

  initial begin
    rst_n = 0; btn_n = 4'hF; prog_sw = 0; digit_ready = 0;
    repeat (3) tick();
    chk("reset_valid", 8'(digit_valid), 8'd0);
    rst_n = 1;
    repeat (3) tick();

    // Button 2 held: digit 2 first visible after the 8th edge (edge 7).
    btn_n = 4'b1011; first = -1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (first < 0 && digit_valid) first = k;
    end
    chk("latency", 8'(first), 8'd7);
    chk("held_digit2", 8'(digit), 8'd2);
    repeat (5) tick();
    chk("held_until_ready", 8'(digit_valid), 8'd1);
    digit_ready = 1; tick(); digit_ready = 0;
    chk("accept_drop", 8'(digit_valid), 8'd0);
    tick();
    chk("held_btn_no_repeat", 8'(digit_valid), 8'd0);
    btn_n = 4'hF; repeat (8) tick();

    // Glitch of three samples on button 1 is filtered.
    btn_n = 4'b1101; repeat (3) tick();
    btn_n = 4'hF; ovf_cnt = 0;
    for (int k = 0; k < 10; k++) begin tick(); if (digit_valid || overflow) ovf_cnt++; end
    chk("glitch_ignored", 8'(ovf_cnt), 8'd0);

    // Digit 0 held unaccepted, then button 3 pressed: one overflow, digit stays 0.
    btn_n = 4'b1110; repeat (10) tick();
    btn_n = 4'b0110; ovf_cnt = 0;
    for (int k = 0; k < 12; k++) begin tick(); if (overflow) ovf_cnt++; end
    chk("ovf_once", 8'(ovf_cnt), 8'd1);
    chk("ovf_digit_kept", 8'(digit), 8'd0);
    chk("ovf_valid_kept", 8'(digit_valid), 8'd1);
    digit_ready = 1; tick(); digit_ready = 0;
    btn_n = 4'hF; repeat (10) tick();

    // Buttons 1 and 3 fall together.
    btn_n = 4'b0101; ovf_cnt = 0;
    for (int k = 0; k < 12; k++) begin tick(); if (overflow) ovf_cnt++; end
`ifdef KEYPAD_MULTI_PRESS_REJECT_EN
    chk("multi_valid", 8'(digit_valid), 8'd0);
    chk("multi_ovf", 8'(ovf_cnt), 8'd1);
`else
    chk("multi_valid", 8'(digit_valid), 8'd1);
    chk("multi_digit", 8'(digit), 8'd1);
    chk("multi_ovf", 8'(ovf_cnt), 8'd0);
`endif
    digit_ready = 1; tick(); digit_ready = 0;
    btn_n = 4'hF; repeat (10) tick();

    // Programming switch on then off.
    prog_sw = 1; rise_cnt = 0; fall_cnt = 0;
    for (int k = 0; k < 12; k++) begin tick(); rise_cnt += int'(prog_rise); fall_cnt += int'(prog_fall); end
    chk("prog_rise_cnt", 8'(rise_cnt), 8'd1);
    chk("prog_level_hi", 8'(prog_level), 8'd1);
    prog_sw = 0;
    for (int k = 0; k < 12; k++) begin tick(); rise_cnt += int'(prog_rise); fall_cnt += int'(prog_fall); end
    chk("prog_rise_total", 8'(rise_cnt), 8'd1);
    chk("prog_fall_cnt", 8'(fall_cnt), 8'd1);
    chk("prog_level_lo", 8'(prog_level), 8'd0);

    // Reset while a digit is held; button stays down and re-fires after reset.
    prog_sw = 1; btn_n = 4'b1011; repeat (12) tick();
    chk("pre_reset_valid", 8'(digit_valid), 8'd1);
    rst_n = 0; tick(); rst_n = 1;
    chk("rst_outputs", {2'b00, digit_valid, digit, overflow, prog_level, prog_rise | prog_fall}, 8'd0);
    tick();
    chk("rst_no_ovf", 8'(overflow), 8'd0);
    repeat (9) tick();
    chk("refire_after_reset", 8'(digit_valid), 8'd1);
    chk("refire_digit", 8'(digit), 8'd2);
    digit_ready = 1; tick(); digit_ready = 0;
    btn_n = 4'hF; prog_sw = 0; repeat (10) tick();

    // Random activity against the model.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        r = int'($urandom_range(0, 4));
        if (r == 4) prog_sw = ~prog_sw;
        else btn_n[r] = ~btn_n[r];
      end
      digit_ready = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
